// File: rtl/lut_neuron_pkg.sv
// Shared types and defaults for the programmable truth-table neuron family.
package lut_neuron_pkg;
  localparam int unsigned IN_BITS_DEF  = 7;
  localparam int unsigned OUT_BITS_DEF = 2;

  typedef enum logic [1:0] {IDLE, LOAD, RUN, PEND} state_t;

  function automatic int unsigned depth(input int unsigned in_bits);
    return 32'd1 << in_bits;
  endfunction
endpackage

// File: rtl/lut_neuron_prog_if.sv
// Config stream plus lookup valid/ready stream of the programmable neuron.
interface lut_neuron_prog_if
  import lut_neuron_pkg::*;
#(
  parameter int unsigned IN_BITS  = IN_BITS_DEF,
  parameter int unsigned OUT_BITS = OUT_BITS_DEF
);
  logic                cfg_start;
  logic                cfg_valid;
  logic                cfg_ready;
  logic [OUT_BITS-1:0] cfg_data;
  logic                cfg_last;
  logic                cfg_done;
  logic                cfg_error;
  logic                programmed;
  logic                in_valid;
  logic                in_ready;
  logic [IN_BITS-1:0]  in_code;
  logic                out_valid;
  logic                out_ready;
  logic [OUT_BITS-1:0] out_data;

  modport slave (
    input  cfg_start, cfg_valid, cfg_data, cfg_last, in_valid, in_code, out_ready,
    output cfg_ready, cfg_done, cfg_error, programmed, in_ready, out_valid, out_data
  );

  modport master (
    output cfg_start, cfg_valid, cfg_data, cfg_last, in_valid, in_code, out_ready,
    input  cfg_ready, cfg_done, cfg_error, programmed, in_ready, out_valid, out_data
  );
endinterface

// File: rtl/lut_neuron_ram.sv
// Truth-table storage: synchronous write, asynchronous read, not reset.
module lut_neuron_ram
  import lut_neuron_pkg::*;
#(
  parameter int unsigned ADDR_BITS = IN_BITS_DEF,
  parameter int unsigned DATA_BITS = OUT_BITS_DEF
) (
  input  logic                 clk,
  input  logic                 i_we,
  input  logic [ADDR_BITS-1:0] i_waddr,
  input  logic [DATA_BITS-1:0] i_wdata,
  input  logic [ADDR_BITS-1:0] i_raddr,
  output logic [DATA_BITS-1:0] o_rdata
);
  localparam int unsigned DEPTH = depth(ADDR_BITS);

  (* ram_style = "distributed" *) logic [DATA_BITS-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/lut_neuron_prog.sv
// Run-time programmable truth-table neuron: config loader FSM, table RAM and
// a single registered lookup output stage with pass-through backpressure.
module lut_neuron_prog
  import lut_neuron_pkg::*;
#(
  parameter int unsigned IN_BITS  = IN_BITS_DEF,
  parameter int unsigned OUT_BITS = OUT_BITS_DEF
) (
  input logic              clk,
  input logic              rst,
  lut_neuron_prog_if.slave bus
);
  localparam int unsigned        DEPTH     = depth(IN_BITS);
  localparam logic [IN_BITS-1:0] LAST_ADDR = IN_BITS'(DEPTH - 1);

  state_t              r_state, w_next;
  logic [IN_BITS-1:0]  r_wr_addr;
  logic                r_programmed, r_cfg_error, r_cfg_done, r_out_valid;
  logic [OUT_BITS-1:0] r_out_data, w_rd_data;
  logic                w_beat, w_at_end, w_good, w_bad, w_enter_load;
  logic                w_in_ready, w_accept;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next       = r_state;
    w_beat       = 1'b0;
    w_good       = 1'b0;
    w_bad        = 1'b0;
    w_enter_load = 1'b0;
    w_at_end     = (r_wr_addr == LAST_ADDR);
    case (r_state)
      IDLE: if (bus.cfg_start) begin
        w_next       = LOAD;
        w_enter_load = 1'b1;
      end
      LOAD: begin
        // A restart pulse wins over a coincident beat; the load begins again at 0.
        if (bus.cfg_start) begin
          w_enter_load = 1'b1;
        end else if (bus.cfg_valid) begin
          w_beat = 1'b1;
          if (bus.cfg_last && w_at_end) begin
            w_good = 1'b1;
            w_next = RUN;
          end else if (bus.cfg_last || w_at_end) begin
            w_bad  = 1'b1;
            w_next = IDLE;
          end
        end
      end
      RUN: if (bus.cfg_start) begin
        if (r_out_valid) begin
          w_next = PEND;
        end else begin
          w_next       = LOAD;
          w_enter_load = 1'b1;
        end
      end
      PEND: if (!r_out_valid) begin
        w_next       = LOAD;
        w_enter_load = 1'b1;
      end
      default: w_next = IDLE;
    endcase
  end

  assign w_in_ready = (r_state == RUN) && (!r_out_valid || bus.out_ready);
  assign w_accept   = bus.in_valid && w_in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_addr    <= '0;
      r_programmed <= 1'b0;
      r_cfg_error  <= 1'b0;
      r_cfg_done   <= 1'b0;
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
    end else begin
      r_cfg_done <= w_good;
      if (w_enter_load) begin
        r_wr_addr    <= '0;
        r_programmed <= 1'b0;
        r_cfg_error  <= 1'b0;
      end else if (w_beat) begin
        r_wr_addr <= r_wr_addr + 1'b1;
      end
      if (w_good) r_programmed <= 1'b1;
      if (w_bad) begin
        r_cfg_error  <= 1'b1;
        r_programmed <= 1'b0;
      end
      if (w_accept) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_rd_data;
      end else if (bus.out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  lut_neuron_ram #(
    .ADDR_BITS(IN_BITS),
    .DATA_BITS(OUT_BITS)
  ) u_ram (
    .clk    (clk),
    .i_we   (w_beat),
    .i_waddr(r_wr_addr),
    .i_wdata(bus.cfg_data),
    .i_raddr(bus.in_code),
    .o_rdata(w_rd_data)
  );

  assign bus.cfg_ready  = (r_state == LOAD);
  assign bus.cfg_done   = r_cfg_done;
  assign bus.cfg_error  = r_cfg_error;
  assign bus.programmed = r_programmed;
  assign bus.in_ready   = w_in_ready;
  assign bus.out_valid  = r_out_valid;
  assign bus.out_data   = r_out_data;
endmodule

// File: tb/tb_lut_neuron_prog.sv
// Self-checking bench for lut_neuron_prog: vector table, directed sequences and
// a queue-based scoreboard for random lookup traffic.
module tb_lut_neuron_prog;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  lut_neuron_prog_if #(.IN_BITS(7), .OUT_BITS(2)) bus ();

  lut_neuron_prog #(.IN_BITS(7), .OUT_BITS(2)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic [6:0] code;
    logic [1:0] exp;
  } vec_t;

  int         n_cmp = 0;
  int         n_bad = 0;
  int         n_out = 0;
  logic [1:0] ld_tbl  [128];
  logic [1:0] mdl_tbl [128];
  logic [1:0] exp_q   [$];
  bit         run_mode = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic fill_random();
    for (int i = 0; i < 128; i++) ld_tbl[i] = 2'($urandom_range(0, 3));
  endtask

  task automatic commit();
    for (int i = 0; i < 128; i++) mdl_tbl[i] = ld_tbl[i];
    run_mode = 1'b1;
  endtask

  // Sends beats 0..nbeats-1 of ld_tbl with random gaps; cfg_last on beat last_beat.
  task automatic load(input bit send_start, input int nbeats, input int last_beat);
    int beat  = 0;
    int guard = 0;
    if (send_start) begin
      bus.cfg_start = 1'b1;
      next_cycle();
      bus.cfg_start = 1'b0;
    end
    while (beat < nbeats && guard < 1000) begin
      bus.cfg_valid = ($urandom_range(0, 3) != 0);
      bus.cfg_data  = ld_tbl[beat];
      bus.cfg_last  = (beat == last_beat);
      #1;
      check("cfg_ready_in_load", bus.cfg_ready, 1);
      @(posedge clk);
      if (bus.cfg_valid) beat++;
      @(negedge clk);
      guard++;
    end
    bus.cfg_valid = 1'b0;
    bus.cfg_last  = 1'b0;
    if (beat < nbeats) begin
      n_cmp++;
      n_bad++;
      $display("FAIL load_timeout: got %0d beats expected %0d", beat, nbeats);
    end
  endtask

  // One lookup cycle checked against the expected-result queue.
  task automatic lk_cycle(input bit iv, input logic [6:0] code, input bit ordy);
    bit exp_ir;
    bus.in_valid  = iv;
    bus.in_code   = code;
    bus.out_ready = ordy;
    #1;
    exp_ir = run_mode && (exp_q.size() == 0 || ordy);
    check("in_ready", bus.in_ready, exp_ir);
    check("out_valid", bus.out_valid, exp_q.size() != 0);
    if (bus.out_valid === 1'b1 && ordy) n_out++;
    if (exp_q.size() != 0) begin
      check("out_data", bus.out_data, exp_q[0]);
      if (ordy) void'(exp_q.pop_front());
    end
    if (iv && exp_ir) exp_q.push_back(mdl_tbl[code]);
    next_cycle();
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int g = 0; g < 8 && exp_q.size() != 0; g++) lk_cycle(1'b0, 7'd0, 1'b1);
  endtask

  task automatic rand_stream(input int n);
    for (int i = 0; i < n; i++)
      lk_cycle(1'($urandom_range(0, 1)), 7'($urandom), ($urandom_range(0, 3) != 0));
    drain();
  endtask

  task automatic check_load_ok();
    check("cfg_done_pulse", bus.cfg_done, 1);
    check("programmed_set", bus.programmed, 1);
    check("cfg_error_clear", bus.cfg_error, 0);
    commit();
    lk_cycle(1'b0, 7'd0, 1'b1);
    check("cfg_done_one_cycle", bus.cfg_done, 0);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs [6];
    vecs[0] = '{7'd77,  2'b01};
    vecs[1] = '{7'd0,   2'b00};
    vecs[2] = '{7'd127, 2'b11};
    vecs[3] = '{7'd64,  2'b00};
    vecs[4] = '{7'd5,   2'b01};
    vecs[5] = '{7'd2,   2'b10};

    rst = 1'b1;
    bus.cfg_start = 1'b0; bus.cfg_valid = 1'b0; bus.cfg_data = '0; bus.cfg_last = 1'b0;
    bus.in_valid  = 1'b0; bus.in_code   = '0;   bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_cfg_ready", bus.cfg_ready, 0);
    check("rst_cfg_done", bus.cfg_done, 0);
    check("rst_cfg_error", bus.cfg_error, 0);
    check("rst_programmed", bus.programmed, 0);
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_data", bus.out_data, 0);
    rst = 1'b0;
    @(negedge clk);
    lk_cycle(1'b1, 7'd3, 1'b1);

    // T1: entry[a] = a[1:0], then table-driven lookups
    for (int i = 0; i < 128; i++) ld_tbl[i] = 2'(i);
    load(1'b1, 128, 127);
    check_load_ok();
    foreach (vecs[k]) begin
      lk_cycle(1'b1, vecs[k].code, 1'b1);
      check("vec_valid", bus.out_valid, 1);
      check("vec_data", bus.out_data, vecs[k].exp);
      lk_cycle(1'b0, 7'd0, 1'b1);
    end
    rand_stream(150);

    // T2: early cfg_last, then partial load, restart mid-load and a good load
    fill_random();
    load(1'b1, 51, 50);
    run_mode = 1'b0;
    check("err_cfg_error", bus.cfg_error, 1);
    check("err_programmed", bus.programmed, 0);
    check("err_cfg_ready", bus.cfg_ready, 0);
    check("err_cfg_done", bus.cfg_done, 0);
    lk_cycle(1'b1, 7'd10, 1'b1);
    check("err_sticky", bus.cfg_error, 1);
    load(1'b1, 20, -1);
    check("restart_err_clear", bus.cfg_error, 0);
    fill_random();
    load(1'b1, 128, 127);
    check_load_ok();
    rand_stream(200);

    // T3: hold backpressure on code 5, then release into a back-to-back stream
    lk_cycle(1'b1, 7'd5, 1'b0);
    for (int i = 0; i < 4; i++) lk_cycle(1'($urandom_range(0, 1)), 7'd9, 1'b0);
    n_out = 0;
    for (int c = 6; c < 16; c++) lk_cycle(1'b1, 7'(c), 1'b1);
    check("b2b_count", n_out, 10);
    drain();

    // T4: full sweep at one result per cycle
    n_out = 0;
    for (int c = 0; c <= 128; c++) lk_cycle(c < 128, 7'(c), 1'b1);
    check("sweep_count", n_out, 128);
    drain();

    // T5: cfg_start while output stalled -> wait for drain, then reload
    lk_cycle(1'b1, 7'd99, 1'b0);
    bus.cfg_start = 1'b1;
    lk_cycle(1'b0, 7'd0, 1'b0);
    bus.cfg_start = 1'b0;
    run_mode = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("pend_cfg_ready", bus.cfg_ready, 0);
      lk_cycle(1'b1, 7'd1, 1'b0);
    end
    lk_cycle(1'b0, 7'd0, 1'b1);
    check("pend_after_drain", bus.cfg_ready, 0);
    next_cycle();
    check("pend_to_load", bus.cfg_ready, 1);
    for (int i = 0; i < 128; i++) ld_tbl[i] = ~mdl_tbl[i];
    load(1'b0, 128, 127);
    check_load_ok();
    rand_stream(200);

    // T6: reset during load beat 60, then full reload
    fill_random();
    load(1'b1, 60, -1);
    rst = 1'b1;
    #1;
    check("mid_rst_cfg_ready", bus.cfg_ready, 0);
    check("mid_rst_programmed", bus.programmed, 0);
    check("mid_rst_in_ready", bus.in_ready, 0);
    check("mid_rst_out_valid", bus.out_valid, 0);
    check("mid_rst_cfg_error", bus.cfg_error, 0);
    run_mode = 1'b0;
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    lk_cycle(1'b1, 7'd3, 1'b1);
    check("post_rst_programmed", bus.programmed, 0);
    fill_random();
    load(1'b1, 128, 127);
    check_load_ok();
    rand_stream(300);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
